// File: rtl/depth_test_writer.sv
// depth_test_writer: consumer end of the rasterizer pixel stream.
// Runs a read-compare-write depth test against the depth BRAM and writes
// passing fragments to the framebuffer at one fragment per clock. It also
// performs the per-frame clear of both buffers.
// Optional build macro DEPTH_STATS_EN adds saturating pass/fail fragment counters.
module depth_test_writer #(
    parameter int unsigned WIDTH       = 320,
    parameter int unsigned HEIGHT      = 240,
    parameter logic [31:0] CLEAR_DEPTH = 32'h7FFF_FFFF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [$clog2(WIDTH)-1:0]          in_x,
    input  logic [$clog2(HEIGHT)-1:0]         in_y,
    input  logic [11:0]                       in_color,
    input  logic [31:0]                       in_depth,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   zb_rd_addr,
    input  logic [31:0]                       zb_rd_data,
    output logic                              zb_wr_en,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   zb_wr_addr,
    output logic [31:0]                       zb_wr_data,
    output logic                              fb_wr_en,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   fb_wr_addr,
    output logic [11:0]                       fb_wr_data,
    input  logic                              clear_start,
    input  logic [11:0]                       clear_color,
    output logic                              busy,
    output logic [31:0]                       pass_count,
    output logic [31:0]                       fail_count
);

    localparam int unsigned ADDR_W = $clog2(WIDTH*HEIGHT);
    localparam int unsigned NPIX   = WIDTH*HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    typedef logic [11:0]        color12_t;
    typedef logic signed [31:0] q16_16_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic              accept_c;
    logic              in_range_c;
    logic [ADDR_W-1:0] acc_addr_c;

    // Stage C: fragment waiting for its BRAM read data
    logic              c_valid;
    logic              c_kill;
    logic [ADDR_W-1:0] c_addr;
    color12_t          c_color;
    q16_16_t           c_depth;

    // Stage W occupancy (the write record itself lives in the zb_wr_* registers)
    logic              w_valid;

    // Stage W2: one-cycle-delayed copy of the depth write record
    logic              w2_valid;
    logic [ADDR_W-1:0] w2_addr;
    q16_16_t           w2_depth;

    q16_16_t           stored_c;
    logic              pass_c;

    logic [ADDR_W-1:0] clr_cnt;
    color12_t          clr_color;

    // Handshake and read address; the read is issued in the accept cycle
    assign in_ready   = (state_q == IDLE) && !rst;
    assign accept_c   = in_valid && in_ready;
    assign zb_rd_addr = accept_c ? acc_addr_c : '0;
    assign busy       = (state_q != IDLE) || c_valid || w_valid || w2_valid;

    // Linear pixel address and bounds check of the incoming fragment
    always_comb begin
        acc_addr_c = ADDR_W'(32'(in_y) * WIDTH + 32'(in_x));
        in_range_c = (32'(in_x) < WIDTH) && (32'(in_y) < HEIGHT);
    end

    // Depth compare with forwarding of the two writes the BRAM read missed
    always_comb begin
        stored_c = zb_rd_data;
        if (zb_wr_en && (zb_wr_addr == c_addr)) begin
            stored_c = zb_wr_data;
        end else if (w2_valid && (w2_addr == c_addr)) begin
            stored_c = w2_depth;
        end
        pass_c = c_valid && !c_kill && (c_depth < stored_c);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: drain the pipeline before sweeping the clear
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!c_valid && !w_valid && !w2_valid) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_cnt == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage C capture and stage W / W2 occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            c_valid  <= 1'b0;
            c_kill   <= 1'b0;
            c_addr   <= '0;
            c_color  <= '0;
            c_depth  <= '0;
            w_valid  <= 1'b0;
            w2_valid <= 1'b0;
            w2_addr  <= '0;
            w2_depth <= '0;
        end else begin
            c_valid <= accept_c;
            if (accept_c) begin
                c_kill  <= !in_range_c;
                c_addr  <= acc_addr_c;
                c_color <= in_color;
                c_depth <= in_depth;
            end
            w_valid  <= c_valid;
            w2_valid <= zb_wr_en;
            w2_addr  <= zb_wr_addr;
            w2_depth <= zb_wr_data;
        end
    end

    // Write ports: clear sweep or passing fragment from stage C
    always_ff @(posedge clk) begin
        if (rst) begin
            zb_wr_en   <= 1'b0;
            zb_wr_addr <= '0;
            zb_wr_data <= '0;
            fb_wr_en   <= 1'b0;
            fb_wr_addr <= '0;
            fb_wr_data <= '0;
        end else if (state_q == CLEAR) begin
            zb_wr_en   <= 1'b1;
            zb_wr_addr <= clr_cnt;
            zb_wr_data <= CLEAR_DEPTH;
            fb_wr_en   <= 1'b1;
            fb_wr_addr <= clr_cnt;
            fb_wr_data <= clr_color;
        end else if (pass_c) begin
            zb_wr_en   <= 1'b1;
            zb_wr_addr <= c_addr;
            zb_wr_data <= c_depth;
            fb_wr_en   <= 1'b1;
            fb_wr_addr <= c_addr;
            fb_wr_data <= c_color;
        end else begin
            zb_wr_en   <= 1'b0;
            fb_wr_en   <= 1'b0;
        end
    end

    // Clear address counter and clear colour latched at the request
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt   <= '0;
            clr_color <= '0;
        end else begin
            if (state_q == CLEAR) begin
                clr_cnt <= (clr_cnt == LAST_ADDR) ? '0 : clr_cnt + ADDR_W'(1);
            end else begin
                clr_cnt <= '0;
            end
            if ((state_q == IDLE) && clear_start) begin
                clr_color <= clear_color;
            end
        end
    end

`ifdef DEPTH_STATS_EN
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic reject_c;
    logic enter_clear_c;

    assign reject_c      = c_valid && !c_kill && !pass_c;
    assign enter_clear_c = (state_q == DRAIN) && (state_d == CLEAR);

    // Saturating pass/fail counters, restarted for each frame clear
    always_ff @(posedge clk) begin
        if (rst || enter_clear_c) begin
            pass_count <= '0;
            fail_count <= '0;
        end else begin
            if (pass_c && (pass_count != CNT_MAX)) begin
                pass_count <= pass_count + 32'd1;
            end
            if (reject_c && (fail_count != CNT_MAX)) begin
                fail_count <= fail_count + 32'd1;
            end
        end
    end
`else
    assign pass_count = '0;
    assign fail_count = '0;
`endif

endmodule

// File: tb/tb_depth_test_writer.sv
// Bench for depth_test_writer: BRAM model, order-preserving reference model of
// depth-buffer contents, and a scoreboard monitor on the write ports.
module tb_depth_test_writer;

    localparam int unsigned W    = 5;
    localparam int unsigned H    = 3;
    localparam int unsigned NPIX = W*H;
    localparam int unsigned AW   = $clog2(NPIX);
    localparam int unsigned XW   = $clog2(W);
    localparam int unsigned YW   = $clog2(H);
    localparam logic [31:0] CLR_Z = 32'h7FFF_FFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [XW-1:0] in_x = '0;
    logic [YW-1:0] in_y = '0;
    logic [11:0]   in_color = '0;
    logic [31:0]   in_depth = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] zb_rd_addr;
    logic [31:0]   zb_rd_data;
    logic          zb_wr_en;
    logic [AW-1:0] zb_wr_addr;
    logic [31:0]   zb_wr_data;
    logic          fb_wr_en;
    logic [AW-1:0] fb_wr_addr;
    logic [11:0]   fb_wr_data;
    logic          clear_start = 1'b0;
    logic [11:0]   clear_color = '0;
    logic          busy;
    logic [31:0]   pass_count;
    logic [31:0]   fail_count;

    always #5 clk = ~clk;

    depth_test_writer #(.WIDTH(W), .HEIGHT(H), .CLEAR_DEPTH(CLR_Z)) dut (
        .clk(clk), .rst(rst),
        .in_x(in_x), .in_y(in_y), .in_color(in_color), .in_depth(in_depth),
        .in_valid(in_valid), .in_ready(in_ready),
        .zb_rd_addr(zb_rd_addr), .zb_rd_data(zb_rd_data),
        .zb_wr_en(zb_wr_en), .zb_wr_addr(zb_wr_addr), .zb_wr_data(zb_wr_data),
        .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
        .clear_start(clear_start), .clear_color(clear_color),
        .busy(busy), .pass_count(pass_count), .fail_count(fail_count)
    );

    // Depth BRAM: 1-cycle read latency, read-first
    logic [31:0] zmem [0:(1<<AW)-1];
    always @(posedge clk) begin
        zb_rd_data <= zmem[zb_rd_addr];
        if (zb_wr_en) zmem[zb_wr_addr] <= zb_wr_data;
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int clr_writes = 0;
    int last_clr_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;     // required write cycle, -1 = not timed
        bit            is_clr;
        logic [AW-1:0] addr;
        logic [31:0]   z;
        logic [11:0]   c;
    } exp_t;

    exp_t sbq[$];

    // Reference: current depth per pixel and expected counters
    logic signed [31:0] ref_z  [NPIX];
    logic signed [31:0] prev_z [NPIX];
    int exp_pass = 0;
    int exp_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_frag(input int x, input int y, input logic [11:0] c, input logic [31:0] d);
        int   a;
        exp_t e;
        if (x < int'(W) && y < int'(H)) begin
            a = y*int'(W) + x;
            if ($signed(d) < ref_z[a]) begin
                ref_z[a] = d;
                e.cyc = cyc + 2; e.is_clr = 1'b0; e.addr = AW'(a); e.z = d; e.c = c;
                sbq.push_back(e);
                exp_pass++;
            end else begin
                exp_fail++;
            end
        end
    endtask

    task automatic model_clear(input logic [11:0] cc);
        exp_t e;
        for (int i = 0; i < int'(NPIX); i++) begin
            prev_z[i] = ref_z[i];
            ref_z[i]  = CLR_Z;
            e.cyc = -1; e.is_clr = 1'b1; e.addr = AW'(i); e.z = CLR_Z; e.c = cc;
            sbq.push_back(e);
        end
        exp_pass = 0;
        exp_fail = 0;
    endtask

    // Monitor: every write must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (zb_wr_en || fb_wr_en) begin
            chk("wr_en_pair", 64'(zb_wr_en), 64'(fb_wr_en));
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual addr=%0d z=%0h required=no write", zb_wr_addr, zb_wr_data);
            end else begin
                e = sbq.pop_front();
                chk("zb_wr_addr", 64'(zb_wr_addr), 64'(e.addr));
                chk("zb_wr_data", 64'(zb_wr_data), 64'(e.z));
                chk("fb_wr_addr", 64'(fb_wr_addr), 64'(e.addr));
                chk("fb_wr_data", 64'(fb_wr_data), 64'(e.c));
                if (e.cyc >= 0) chk("wr_latency", 64'(cyc), 64'(e.cyc));
                if (e.is_clr) begin
                    clr_writes++;
                    if (e.addr != '0) chk("clr_consecutive", 64'(cyc), 64'(last_clr_cyc + 1));
                    last_clr_cyc = cyc;
                end
            end
        end
    end

    task automatic check_counters(input string tag);
`ifdef DEPTH_STATS_EN
        chk({tag, "_pass_count"}, 64'(pass_count), 64'(exp_pass));
        chk({tag, "_fail_count"}, 64'(fail_count), 64'(exp_fail));
`else
        chk({tag, "_pass_count"}, 64'(pass_count), 64'(0));
        chk({tag, "_fail_count"}, 64'(fail_count), 64'(0));
`endif
    endtask

    task automatic rst_checks(input string tag);
        chk({tag, "_zb_wr_en"},   64'(zb_wr_en),   64'(0));
        chk({tag, "_zb_wr_addr"}, 64'(zb_wr_addr), 64'(0));
        chk({tag, "_zb_wr_data"}, 64'(zb_wr_data), 64'(0));
        chk({tag, "_fb_wr_en"},   64'(fb_wr_en),   64'(0));
        chk({tag, "_fb_wr_addr"}, 64'(fb_wr_addr), 64'(0));
        chk({tag, "_fb_wr_data"}, 64'(fb_wr_data), 64'(0));
        chk({tag, "_zb_rd_addr"}, 64'(zb_rd_addr), 64'(0));
        chk({tag, "_busy"},       64'(busy),       64'(0));
        chk({tag, "_in_ready"},   64'(in_ready),   64'(0));
        chk({tag, "_pass_count"}, 64'(pass_count), 64'(0));
        chk({tag, "_fail_count"}, 64'(fail_count), 64'(0));
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid    = 1'b0;
        clear_start = 1'b0;
    endtask

    task automatic frag(input int x, input int y, input logic [11:0] c, input logic [31:0] d,
                        input bit with_clr, input logic [11:0] cc);
        @(posedge clk); #1;
        in_valid    = 1'b1;
        in_x        = XW'(x);
        in_y        = YW'(y);
        in_color    = c;
        in_depth    = d;
        clear_start = with_clr;
        clear_color = cc;
        @(negedge clk);
        chk("in_ready_accept", 64'(in_ready), 64'(1));
        model_frag(x, y, c, d);
        if (with_clr) model_clear(cc);
    endtask

    task automatic rand_frag(input bit with_clr);
        int x, y, dv;
        logic [31:0] d;
        x  = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 7));
        y  = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
        dv = int'($urandom_range(0, 15)) - 8;
        d  = 32'(dv) << 16;
        if ($urandom_range(0, 9) == 0) d = CLR_Z;
        if ($urandom_range(0, 9) == 0) d = $urandom;
        frag(x, y, 12'($urandom), d, with_clr, 12'($urandom));
    endtask

    // Clear request with no fragment; optionally checks the stall window
    task automatic do_clear(input logic [11:0] cc, input bit check_window);
        @(posedge clk); #1;
        in_valid    = 1'b0;
        clear_start = 1'b1;
        clear_color = cc;
        @(negedge clk);
        chk("clr_req_ready", 64'(in_ready), 64'(1));
        model_clear(cc);
        idle();
        clear_color = ~cc;
        if (check_window) begin
            for (int i = 0; i <= int'(NPIX); i++) begin
                if (i != 0) idle();
                @(negedge clk);
                chk("clr_in_ready_low", 64'(in_ready), 64'(0));
                chk("clr_busy_high", 64'(busy), 64'(1));
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        idle();
        @(negedge clk);
        while (busy && n < int'(NPIX) + 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_busy_low"}, 64'(busy), 64'(0));
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        chk({tag, "_sb_drained"}, 64'(sbq.size()), 64'(0));
        check_counters(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  found;
        for (int i = 0; i < (1 << AW); i++) zmem[i] = '0;
        for (int i = 0; i < int'(NPIX); i++) begin
            ref_z[i]  = '0;
            prev_z[i] = '0;
        end

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_checks("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'(in_ready), 64'(1));

        // Full clear
        clr_writes = 0;
        do_clear(12'h00F, 1'b1);
        wait_idle("clear0");
        chk("clear_write_count", 64'(clr_writes), 64'(NPIX));

        // Single fragment
        frag(1, 1, 12'hF00, 32'h0001_0000, 1'b0, 12'h000);
        wait_idle("single");

        // Back-to-back at one pixel: equal depth and forwarding from W and W2
        frag(2, 0, 12'h111, 32'h0003_0000, 1'b0, 12'h000);
        frag(2, 0, 12'h222, 32'h0002_0000, 1'b0, 12'h000);
        frag(2, 0, 12'h333, 32'h0002_0000, 1'b0, 12'h000);
        frag(2, 0, 12'h444, 32'h0004_0000, 1'b0, 12'h000);
        wait_idle("b2b");

        // Out-of-range fragments
        frag(5, 0, 12'h555, 32'h8000_0000, 1'b0, 12'h000);
        frag(0, 3, 12'h666, 32'h8000_0000, 1'b0, 12'h000);
        frag(7, 3, 12'h777, 32'h8000_0000, 1'b0, 12'h000);
        wait_idle("oor");

        // Clear requested with two fragments in flight
        frag(3, 2, 12'hABC, 32'hFFFF_0000, 1'b0, 12'h000);
        frag(4, 1, 12'hDEF, 32'h0000_8000, 1'b0, 12'h000);
        clr_writes = 0;
        do_clear(12'h0F0, 1'b1);
        wait_idle("clr_inflight");
        chk("clr_inflight_count", 64'(clr_writes), 64'(NPIX));

        // Populate, then reset in the middle of a clear
        for (int i = 0; i < 10; i++) rand_frag(1'b0);
        wait_idle("prefill");
        do_clear(12'h0A5, 1'b0);
        n = 0;
        found = 1'b0;
        while (!found && n < int'(NPIX) + 20) begin
            @(negedge clk);
            if (zb_wr_en && zb_wr_addr == AW'(3)) found = 1'b1;
            n++;
        end
        chk("rst_point_found", 64'(found), 64'(1));
        rst      = 1'b1;
        in_valid = 1'b1;
        in_x     = XW'(3);
        in_y     = YW'(1);
        @(posedge clk); #1;
        sbq.delete();
        for (int i = 4; i < int'(NPIX); i++) ref_z[i] = prev_z[i];
        exp_pass = 0;
        exp_fail = 0;
        @(negedge clk);
        rst_checks("midclear_reset");
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_midclear", 64'(in_ready), 64'(1));
        frag(4, 1, 12'h123, 32'h0001_8000, 1'b0, 12'h000);
        frag(0, 0, 12'h456, 32'h0001_8000, 1'b0, 12'h000);
        wait_idle("after_reset");

        // Randomized stream with occasional clears
        for (int i = 0; i < 400; i++) begin
            n = int'($urandom_range(0, 99));
            if (n < 20) begin
                idle();
            end else if (n < 23) begin
                rand_frag(1'b1);
                wait_idle("rnd_clear");
            end else begin
                rand_frag(1'b0);
            end
        end
        wait_idle("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/depth_test_writer.md
Name: depth_test_writer

Overview:
- Consumer end of the rasterizer pixel stream.
- Accepts interpolated fragments (x, y, RGB444 colour, Q16.16 depth) over valid/ready.
- Performs a read-compare-write depth test against a single-port-per-direction depth BRAM and writes passing fragments to the framebuffer BRAM.
- Also owns the per-frame clear of both buffers.
- Sustains 1 fragment/clk with in-pipeline read-after-write forwarding.

Parameters:
- WIDTH, 320, framebuffer width in pixels.
- HEIGHT, 240, framebuffer height in pixels.
- CLEAR_DEPTH, 32'h7FFF_FFFF, depth value written by clear (farthest).
- Derived localparam ADDR_W = $clog2(WIDTH*HEIGHT).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_x  in  $clog2(WIDTH)  fragment x
- in_y  in  $clog2(HEIGHT)  fragment y
- in_color  in  12 (color12_t)  fragment colour
- in_depth  in  32 (q16_16_t)  fragment depth, signed
- in_valid  in  1  fragment valid
- in_ready  out  1  fragment accept
- zb_rd_addr  out  ADDR_W  depth read address (BRAM, 1-cycle read latency, read-first)
- zb_rd_data  in  32  depth read data
- zb_wr_en  out  1  depth write enable
- zb_wr_addr  out  ADDR_W  depth write address
- zb_wr_data  out  32  depth write data
- fb_wr_en  out  1  framebuffer write enable
- fb_wr_addr  out  ADDR_W  framebuffer write address
- fb_wr_data  out  12  framebuffer write colour
- clear_start  in  1  pulse: request buffer clear
- clear_color  in  12  colour written during clear
- busy  out  1  any fragment in flight or clear active
- pass_count  out  32  fragments written (feature)
- fail_count  out  32  fragments rejected (feature)

Behaviour:
- Handshake: transfer when in_valid && in_ready. in_ready = (state==IDLE) && !rst.
- No internal stall while IDLE; both BRAM ports are always ready.
- Address: addr = in_y*WIDTH + in_x, computed at accept, ADDR_W bits.
- Out-of-range fragments (x>=WIDTH or y>=HEIGHT) are accepted, flow through the pipeline with kill=1, and never write. They count toward neither counter.
- Pipeline: accept cycle n drives zb_rd_addr combinationally. Stage C (cycle n+1) holds the fragment and sees zb_rd_data. Compare result is registered into stage W. zb_wr_*/fb_wr_* are driven from W registers in cycle n+2.
- Latency: accept to write enable = 2 cycles.
- Depth test: pass iff $signed(in_depth) < $signed(stored), strictly less; equal depth fails.
  - On pass: write in_depth to zbuf and in_color to fb at the same address, same cycle.
- Forwarding: stored = zb_rd_data unless overridden.
  - Override from W: W valid, W pass, W.addr == C.addr.
  - Else override from W2: a one-cycle-delayed copy of W's write record.
  - W has priority over W2.
  - This covers the two writes not yet visible to the BRAM read.
- FSM states:
  - IDLE: accept fragments.
  - DRAIN: in_ready=0; waits until C, W, W2 are all empty.
  - CLEAR: one address per cycle, 0..WIDTH*HEIGHT-1; writes CLEAR_DEPTH to zbuf and clear_color (latched at clear_start) to fb on both write ports.
- Transitions:
  - IDLE→DRAIN on clear_start.
  - DRAIN→CLEAR when the pipeline is empty, same cycle as the check.
  - CLEAR→IDLE after the write to the last address.
  - Clear takes WIDTH*HEIGHT cycles of write.
- clear_start is ignored outside IDLE.
- If clear_start and in_valid are asserted together in IDLE, the fragment is accepted and the clear starts next cycle.
- busy = state!=IDLE || any stage valid.
- Reset (any time, including mid-clear):
  - state=IDLE, all stage valids=0, clear counter=0.
  - All outputs 0: zb_rd_addr, zb_wr_*, fb_wr_*, busy, counters.
  - in_ready=0 while rst is high, 1 the cycle after.
  - An interrupted clear is abandoned, leaving partial contents.

Optional Feature:
- Macro DEPTH_STATS_EN.
- When defined:
  - pass_count increments on each write; fail_count increments on each in-range rejected fragment.
  - Both saturate at 32'hFFFF_FFFF.
  - Both are zeroed on reset and on entry to CLEAR.
- When undefined: the counters are not instantiated and both ports are tied to 0.

Test Plan:
- Reset, clear with clear_color=12'h00F, WIDTH=4, HEIGHT=2 → exactly 8 cycles of zb_wr_en/fb_wr_en at addrs 0..7, data 32'h7FFF_FFFF / 12'h00F; busy falls; in_ready=1.
- Fragment (1,1,12'hF00,32'h0001_0000) after clear → cycle+2: fb_wr_addr=5, fb_wr_data=12'hF00, zb_wr_data=32'h0001_0000.
- Back-to-back on consecutive cycles at (2,0): depths 0x0003_0000, 0x0002_0000, 0x0002_0000, 0x0004_0000 → writes for the 1st and 2nd only; 3rd fails (equal, forwarded from W); 4th fails (forwarded from W2). With DEPTH_STATS_EN: pass=2, fail=2.
- Fragment x=4 (out of range) → no write on any port, counters unchanged.
- clear_start while 2 fragments are in flight → both fragments write first, then clear begins; in_ready=0 from the cycle after clear_start until the clear completes.
- rst asserted at clear address 3 → next cycle all outputs 0, state IDLE; a subsequent fragment is accepted normally.
